uart_tx_arb: RTL and testbench

Round-robin arbiter that shares the single UART transmitter of the pico system between several byte producers, such as the CPU console path and a switch-event reporter. Each requester offers bytes with a valid/ready handshake. The arbiter grants one owner at a time, forwards that owner's bytes to the transmitter's valid/ready input, and rotates priority so no requester starves. Optional message locking keeps multi-byte messages from interleaving on the serial line.

---
 rtl/uart_tx_arb.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmitter between
// NREQ byte producers.
//
// Handshake: every lane and the transmitter side use valid/ready. A byte
// moves on a cycle where valid && ready are both high. valid may drop
// before acceptance, and the arbiter never holds a copy of the data.
//
// Optional feature: define UART_TX_ARB_LOCK_EN to keep a grant until the
// byte marked req_last. In that build a LOCK_TIMEOUT idle-cycle watchdog
// frees a stalled owner. Without the macro, every byte releases the grant.
module uart_tx_arb #(
  parameter int NREQ         = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] owner, owner_next;
  logic [IDW-1:0] rr_ptr, rr_next;
  logic [IDW-1:0] owner_inc;
  logic [IDW-1:0] pick;
  logic           found;
  logic [7:0]     lane [NREQ];
  logic           own_valid;
  logic           xfer;
  logic           release_now;

  // Split the flat data bus into one byte per lane.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lane[i] = req_data[8*i +: 8];
    end
  end

  assign own_valid = req_valid[owner];
  assign owner_inc = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign busy      = (state == BUSY);
  assign grant_id  = owner;
  assign tx_valid  = busy && own_valid;
  assign tx_data   = busy ? lane[owner] : 8'h00;
  assign xfer      = tx_valid && tx_ready;

  // Only the owner sees the transmitter's ready; all other lanes stall.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = busy && (owner == IDW'(i)) && tx_ready;
    end
  end

  // Round-robin scan: first valid lane at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
        found = 1'b1;
        pick  = IDW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT);

  logic [CW-1:0] idle_cnt;
  logic          timeout_hit;

  // A stalled owner is dropped on its LOCK_TIMEOUT-th consecutive idle cycle.
  assign timeout_hit = busy && !own_valid && (idle_cnt == CW'(LOCK_TIMEOUT - 1));
  assign release_now = (xfer && req_last[owner]) || timeout_hit;
  assign timeout_err = timeout_hit;

  // Count consecutive owner-idle cycles while busy; any valid cycle clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (busy && !own_valid && !timeout_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  logic unused_cfg;

  // req_last and the timeout length only matter when locking is built in.
  assign unused_cfg  = ^{req_last, 32'(LOCK_TIMEOUT)};
  assign release_now = xfer;
  assign timeout_err = 1'b0;
`endif

  // State, owner and priority pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_next;
    end
  end

  // Next-state logic: grant from IDLE, release from BUSY.
  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          owner_next = pick;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_next = IDLE;
          rr_next    = owner_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (NREQ=2, LOCK_TIMEOUT=4). Expected
// {grant_id, byte} pairs are queued as stimulus is planned, and a negedge
// monitor pops one for every transmitter handshake.
module tb_uart_tx_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [15:0] req_data;
  logic [1:0] req_last;
  logic [1:0] req_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [0:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  uart_tx_arb #(.NREQ(2), .LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  // Scoreboard: every transmitter handshake must match the queue head.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", {23'h0, grant_id, tx_data}, 32'h1ff);
      end else begin
        check("xfer", {23'h0, grant_id, tx_data}, {23'h0, exp_q.pop_front()});
      end
    end
  end

  logic [7:0] msg [3];
  int  i0, n1, n1_target;
  logic a0, a1;

  initial begin
    msg[0] = 8'h48; msg[1] = 8'h49; msg[2] = 8'h0A;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    next_cycle();
    rst = 1'b0;

    // Reset in the middle of a stalled lane1 grant.
    req_valid = 2'b10; req_data = 16'h5500; req_last = 2'b10;
    next_cycle();
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'h1);
    check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
    check("pre_rst_tx_data", 32'(tx_data), 32'h55);
    check("pre_rst_grant", 32'(grant_id), 32'h1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    req_valid = '0;
    next_cycle();
    rst = 1'b0;

    // Round robin with both lanes always valid.
    exp_q.push_back({1'b0, 8'h41}); exp_q.push_back({1'b1, 8'h42});
    exp_q.push_back({1'b0, 8'h41}); exp_q.push_back({1'b1, 8'h42});
    req_valid = 2'b11; req_data = 16'h4241; req_last = 2'b11; tx_ready = 1'b1;
    @(negedge clk);
    check("rr_idle_tx_valid", 32'(tx_valid), 32'h0);
    check("rr_idle_req_ready", 32'(req_ready), 32'h0);
    next_cycle();
    repeat (7) next_cycle();
    req_valid = '0;
    check("rr_drain", 32'(exp_q.size()), 32'h0);

    // Backpressure on a lane1 byte.
    req_valid = 2'b10; req_data = 16'h3300; req_last = 2'b10; tx_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h33});
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_tx_valid", 32'(tx_valid), 32'h1);
      check("bp_tx_data", 32'(tx_data), 32'h33);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      next_cycle();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp_req_ready_go", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("bp_busy_after", 32'(busy), 32'h0);
    check("bp_drain", 32'(exp_q.size()), 32'h0);
    next_cycle();

    // Three-byte message on lane0 against a lane1 that keeps offering 0x58.
`ifdef UART_TX_ARB_LOCK_EN
    n1_target = 1;
    exp_q.push_back({1'b0, 8'h48}); exp_q.push_back({1'b0, 8'h49});
    exp_q.push_back({1'b0, 8'h0A}); exp_q.push_back({1'b1, 8'h58});
`else
    n1_target = 2;
    exp_q.push_back({1'b0, 8'h48}); exp_q.push_back({1'b1, 8'h58});
    exp_q.push_back({1'b0, 8'h49}); exp_q.push_back({1'b1, 8'h58});
    exp_q.push_back({1'b0, 8'h0A});
`endif
    i0 = 0; n1 = 0;
    for (int c = 0; c < 40 && (i0 < 3 || n1 < n1_target); c++) begin
      req_valid[0] = (i0 < 3);
      req_data[7:0] = (i0 < 3) ? msg[i0] : 8'h00;
      req_last[0] = (i0 == 2);
      req_valid[1] = (n1 < n1_target);
      req_data[15:8] = 8'h58;
      req_last[1] = 1'b1;
      @(negedge clk);
      a0 = req_ready[0];
      a1 = req_ready[1];
      check("msg_timeout_err", 32'(timeout_err), 32'h0);
      next_cycle();
      if (a0) i0++;
      if (a1) n1++;
    end
    req_valid = '0;
    check("msg_drain", 32'(exp_q.size()), 32'h0);
    next_cycle();

`ifdef UART_TX_ARB_LOCK_EN
    // Lock timeout: lane0 stalls after one non-last byte, lane1 waits.
    req_valid = 2'b11; req_data = 16'h2211; req_last = 2'b10; tx_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    next_cycle();
    next_cycle();
    req_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("to_wait_err", 32'(timeout_err), 32'h0);
      check("to_wait_busy", 32'(busy), 32'h1);
      next_cycle();
    end
    @(negedge clk);
    check("to_pulse", 32'(timeout_err), 32'h1);
    exp_q.push_back({1'b1, 8'h22});
    next_cycle();
    @(negedge clk);
    check("to_busy_after", 32'(busy), 32'h0);
    check("to_pulse_end", 32'(timeout_err), 32'h0);
    next_cycle();
    @(negedge clk);
    check("to_lane1_busy", 32'(busy), 32'h1);
    check("to_lane1_grant", 32'(grant_id), 32'h1);
    next_cycle();
    req_valid = '0;
    check("to_drain", 32'(exp_q.size()), 32'h0);
    next_cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
